branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_meta_reg.sv | 41 ++++
 rtl/branch_resolver.sv | 139 +++++++++++++
 tb/tb_branch_resolver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolution path:
// opcodes, predictor counter encodings, resolver FSM states and pipeline metadata.
package bp_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      CNT_STRONG_NT = 2'b00,
      CNT_WEAK_NT   = 2'b01,
      CNT_WEAK_T    = 2'b10,
      CNT_STRONG_T  = 2'b11
   } bp_cnt2_e;

   typedef enum logic [0:0] {
      RES_ARMED = 1'b0,
      RES_DONE  = 1'b1
   } res_state_e;

   typedef struct packed {
      logic        valid;
      logic        taken;
      logic [31:0] target;
      logic [31:0] pc;
   } bp_meta_t;

   // An invalid prediction counts as predicted not-taken; a taken prediction
   // is also wrong when it pointed at the wrong target.
   function automatic logic bp_mispredict(input bp_meta_t meta, input logic pcsrc,
                                          input logic [31:0] act_target);
      logic pred_taken;
      pred_taken = meta.valid & meta.taken;
      return (pcsrc != pred_taken) | (pcsrc & pred_taken & (act_target != meta.target));
   endfunction

endpackage

// File: rtl/bp_meta_reg.sv
// One stallable, flushable pipeline stage of prediction metadata.
// A flush overrides a stall and leaves a bubble (valid=0) in the stage.
module bp_meta_reg
   import bp_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     stall_i,
   input  logic     flush_i,
   input  bp_meta_t meta_i,
   output bp_meta_t meta_o
);

   bp_meta_t meta_q;
   bp_meta_t meta_d;

   // Next-state selection: flush > stall > load.
   always_comb begin
      meta_d = meta_q;
      if (flush_i) begin
         meta_d       = meta_i;
         meta_d.valid = 1'b0;
      end else if (!stall_i) begin
         meta_d = meta_i;
      end else begin
         meta_d = meta_q;
      end
   end

   // Stage register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= '0;
      end else begin
         meta_q <= meta_d;
      end
   end

   assign meta_o = meta_q;

endmodule

// File: rtl/branch_resolver.sv
// Resolves B/J-type instructions in Execute against the prediction carried down
// the pipeline, produces redirect/flush/training strobes and performance counters.
module branch_resolver
   import bp_pkg::*;
#(
   parameter int COUNT_W      = 32,
   parameter int RESET_PC_INC = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        PCF,
   input  logic               PredValidF,
   input  logic               PredTakenF,
   input  logic [31:0]        PredTargetF,
   input  logic               StallD,
   input  logic               StallE,
   input  logic               FlushD,
   input  logic               FlushE,
   input  logic               BranchE,
   input  logic               JumpE,
   input  logic               PCSrcE,
   input  logic [31:0]        ActTargetE,
   output logic               MispredictE,
   output logic [31:0]        RedirectPC,
   output logic               FlushFE,
   output logic               StateUpdateEnable,
   output logic               PCSrcUpd,
   output logic [COUNT_W-1:0] BranchCount,
   output logic [COUNT_W-1:0] MispredictCount
);

   localparam logic [31:0]        PC_INC  = 32'(RESET_PC_INC);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

   bp_meta_t            meta_f_s;
   bp_meta_t            meta_d_s;
   bp_meta_t            meta_e_s;
   logic                flush_d_s;
   logic                flush_e_s;
   logic                resolve_s;
   logic                mispredict_s;
   logic [31:0]         redirect_s;
   res_state_e          state_q;
   res_state_e          state_d;
   logic [COUNT_W-1:0]  branch_cnt_q;
   logic [COUNT_W-1:0]  branch_cnt_d;
   logic [COUNT_W-1:0]  mis_cnt_q;
   logic [COUNT_W-1:0]  mis_cnt_d;

   assign meta_f_s = '{valid: PredValidF, taken: PredTakenF, target: PredTargetF, pc: PCF};

   // A mispredict kills the younger instructions in F and D on the same edge.
   assign flush_d_s = FlushD | mispredict_s;
   assign flush_e_s = FlushE | mispredict_s;

   bp_meta_reg u_meta_d (
      .clk     (clk),
      .reset   (reset),
      .stall_i (StallD),
      .flush_i (flush_d_s),
      .meta_i  (meta_f_s),
      .meta_o  (meta_d_s)
   );

   bp_meta_reg u_meta_e (
      .clk     (clk),
      .reset   (reset),
      .stall_i (StallE),
      .flush_i (flush_e_s),
      .meta_i  (meta_d_s),
      .meta_o  (meta_e_s)
   );

   assign resolve_s    = (BranchE | JumpE) & (state_q == RES_ARMED);
   assign mispredict_s = resolve_s & bp_mispredict(meta_e_s, PCSrcE, ActTargetE);
   assign redirect_s   = PCSrcE ? ActTargetE : (meta_e_s.pc + PC_INC);

   // Resolver FSM next state: DONE blocks re-resolution while E is held.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RES_ARMED: begin
            if (resolve_s && StallE) begin
               state_d = RES_DONE;
            end else begin
               state_d = RES_ARMED;
            end
         end
         RES_DONE: begin
            if (!StallE) begin
               state_d = RES_ARMED;
            end else begin
               state_d = RES_DONE;
            end
         end
         default: state_d = RES_ARMED;
      endcase
   end

   // Saturating performance counters.
   always_comb begin
      branch_cnt_d = branch_cnt_q;
      mis_cnt_d    = mis_cnt_q;
      if (resolve_s && (branch_cnt_q != CNT_MAX)) begin
         branch_cnt_d = branch_cnt_q + CNT_ONE;
      end else begin
         branch_cnt_d = branch_cnt_q;
      end
      if (mispredict_s && (mis_cnt_q != CNT_MAX)) begin
         mis_cnt_d = mis_cnt_q + CNT_ONE;
      end else begin
         mis_cnt_d = mis_cnt_q;
      end
   end

   // FSM state and counter registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= RES_ARMED;
         branch_cnt_q <= '0;
         mis_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         branch_cnt_q <= branch_cnt_d;
         mis_cnt_q    <= mis_cnt_d;
      end
   end

   // Every output is forced low while reset is held, whatever the other inputs do.
   assign MispredictE       = reset & mispredict_s;
   assign FlushFE           = reset & mispredict_s;
   assign RedirectPC        = reset ? redirect_s : 32'h0000_0000;
   assign StateUpdateEnable = reset & resolve_s & BranchE;
   assign PCSrcUpd          = reset & PCSrcE;
   assign BranchCount       = reset ? branch_cnt_q : '0;
   assign MispredictCount   = reset ? mis_cnt_q : '0;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scenarios plus randomized traffic for branch_resolver, checked against
// a cycle-level reference model of the prediction pipeline.
module tb_branch_resolver;

   localparam int CW   = 4;
   localparam int INC  = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [31:0]   PCF, PredTargetF, ActTargetE, RedirectPC;
   logic          PredValidF, PredTakenF, StallD, StallE, FlushD, FlushE;
   logic          BranchE, JumpE, PCSrcE;
   logic          MispredictE, FlushFE, StateUpdateEnable, PCSrcUpd;
   logic [CW-1:0] BranchCount, MispredictCount;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: D and E pipeline slots, "E already resolved" flag, counts.
   logic        dv, dt, ev, et, e_done;
   logic [31:0] dtg, dpc, etg, epc;
   int          bc, mc;
   logic        x_res, x_mis;
   logic [31:0] x_redir;

   branch_resolver #(.COUNT_W(CW), .RESET_PC_INC(INC)) dut (
      .clk(clk), .reset(reset), .PCF(PCF), .PredValidF(PredValidF), .PredTakenF(PredTakenF),
      .PredTargetF(PredTargetF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
      .FlushE(FlushE), .BranchE(BranchE), .JumpE(JumpE), .PCSrcE(PCSrcE),
      .ActTargetE(ActTargetE), .MispredictE(MispredictE), .RedirectPC(RedirectPC),
      .FlushFE(FlushFE), .StateUpdateEnable(StateUpdateEnable), .PCSrcUpd(PCSrcUpd),
      .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_eval();
      logic pt;
      x_res   = reset && (BranchE || JumpE) && !e_done;
      pt      = ev && et;
      x_mis   = x_res && ((PCSrcE != pt) || (PCSrcE && pt && (ActTargetE != etg)));
      x_redir = PCSrcE ? ActTargetE : epc + 32'(INC);
   endtask

   task automatic settle();
      #4;
      model_eval();
      chk("MispredictE", {31'd0, MispredictE}, {31'd0, x_mis});
      chk("FlushFE", {31'd0, FlushFE}, {31'd0, x_mis});
      chk("RedirectPC", RedirectPC, reset ? x_redir : 32'd0);
      chk("StateUpdateEnable", {31'd0, StateUpdateEnable}, {31'd0, x_res && BranchE});
      chk("PCSrcUpd", {31'd0, PCSrcUpd}, {31'd0, reset && PCSrcE});
      chk("BranchCount", 32'(BranchCount), reset ? 32'(bc) : 32'd0);
      chk("MispredictCount", 32'(MispredictCount), reset ? 32'(mc) : 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_eval();
      if (!reset) begin
         {dv, dt, dtg, dpc, ev, et, etg, epc} = '0;
         e_done = 1'b0;
         bc = 0;
         mc = 0;
      end else begin
         if (x_res) bc = (bc == MAXC) ? bc : bc + 1;
         if (x_mis) mc = (mc == MAXC) ? mc : mc + 1;
         if (FlushE || x_mis) begin
            ev = 1'b0; et = dt; etg = dtg; epc = dpc;
         end else if (!StallE) begin
            ev = dv; et = dt; etg = dtg; epc = dpc;
         end
         if (FlushD || x_mis) begin
            dv = 1'b0; dt = PredTakenF; dtg = PredTargetF; dpc = PCF;
         end else if (!StallD) begin
            dv = PredValidF; dt = PredTakenF; dtg = PredTargetF; dpc = PCF;
         end
         e_done = StallE ? (e_done || x_res) : 1'b0;
      end
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic idle();
      reset = 1'b1;
      PCF = 32'd0; PredValidF = 1'b0; PredTakenF = 1'b0; PredTargetF = 32'd0;
      StallD = 1'b0; StallE = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
      BranchE = 1'b0; JumpE = 1'b0; PCSrcE = 1'b0; ActTargetE = 32'd0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   // Push one prediction through F and D so that it sits in E afterwards.
   task automatic load_e(input logic [31:0] pc, input logic v, input logic t, input logic [31:0] tg);
      idle();
      PCF = pc; PredValidF = v; PredTakenF = t; PredTargetF = tg;
      step();
      idle();
      step();
   endtask

   initial begin
      {dv, dt, dtg, dpc, ev, et, etg, epc} = '0;
      e_done = 1'b0; bc = 0; mc = 0;
      idle();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;

      // Correctly predicted taken branch.
      do_reset();
      load_e(32'h40, 1'b1, 1'b1, 32'h100);
      BranchE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h100;
      settle();
      chk("hit_mispredict", {31'd0, MispredictE}, 32'd0);
      chk("hit_update", {31'd0, StateUpdateEnable}, 32'd1);
      tick();
      chk("hit_count", 32'(BranchCount), 32'd1);

      // Predicted not-taken but taken; D holds a valid taken prediction that must be killed.
      do_reset();
      PCF = 32'h40; PredValidF = 1'b1; PredTakenF = 1'b0; PredTargetF = 32'h0;
      step();
      PCF = 32'h48; PredTakenF = 1'b1; PredTargetF = 32'h300;
      step();
      PCF = 32'h4c; PredTargetF = 32'h400;
      BranchE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h80;
      settle();
      chk("nt_mispredict", {31'd0, MispredictE}, 32'd1);
      chk("nt_redirect", RedirectPC, 32'h80);
      chk("nt_flushfe", {31'd0, FlushFE}, 32'd1);
      tick();
      chk("nt_miscount", 32'(MispredictCount), 32'd1);
      PredValidF = 1'b0; ActTargetE = 32'h300;
      settle();
      chk("flushed_e_invalid", {31'd0, MispredictE}, 32'd1);
      tick();

      // Predicted taken but not taken: fall through.
      do_reset();
      load_e(32'h40, 1'b1, 1'b1, 32'h100);
      BranchE = 1'b1; PCSrcE = 1'b0;
      settle();
      chk("t_mispredict", {31'd0, MispredictE}, 32'd1);
      chk("t_redirect", RedirectPC, 32'h44);
      tick();

      // Branch held in E for three cycles resolves only once.
      do_reset();
      load_e(32'h40, 1'b1, 1'b1, 32'h100);
      BranchE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h100; StallE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("stall_update", {31'd0, StateUpdateEnable}, (i == 0) ? 32'd1 : 32'd0);
         tick();
      end
      chk("stall_count", 32'(BranchCount), 32'd1);
      idle();
      step();

      // JAL with wrong target: redirect, no training.
      do_reset();
      load_e(32'h40, 1'b1, 1'b1, 32'h200);
      JumpE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h204;
      settle();
      chk("jal_mispredict", {31'd0, MispredictE}, 32'd1);
      chk("jal_redirect", RedirectPC, 32'h204);
      chk("jal_update", {31'd0, StateUpdateEnable}, 32'd0);
      tick();

      // Reset while E is stalled after resolving: next resolution is fresh.
      do_reset();
      load_e(32'h40, 1'b1, 1'b1, 32'h100);
      BranchE = 1'b1; StallE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h100;
      step();
      reset = 1'b0;
      step();
      idle();
      BranchE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h100;
      settle();
      chk("post_reset_update", {31'd0, StateUpdateEnable}, 32'd1);
      chk("post_reset_mispredict", {31'd0, MispredictE}, 32'd1);
      tick();

      // Counter saturation, then reset with active inputs.
      do_reset();
      BranchE = 1'b1; PCSrcE = 1'b1; ActTargetE = 32'h500;
      for (int i = 0; i < MAXC + 3; i++) step();
      chk("sat_branch", 32'(BranchCount), 32'(MAXC));
      chk("sat_mis", 32'(MispredictCount), 32'(MAXC));
      reset = 1'b0;
      settle();
      chk("rst_out_mispredict", {31'd0, MispredictE}, 32'd0);
      chk("rst_out_count", 32'(BranchCount), 32'd0);
      tick();
      reset = 1'b1;
      settle();
      chk("rst_armed", {31'd0, StateUpdateEnable}, 32'd1);
      tick();
      chk("rst_count_restart", 32'(BranchCount), 32'd1);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         reset       = ($urandom_range(0, 49) != 0);
         PCF         = $urandom & 32'hFFFF_FFFC;
         PredValidF  = $urandom_range(0, 3) != 0;
         PredTakenF  = $urandom_range(0, 1) == 1;
         PredTargetF = {24'd0, $urandom_range(0, 3) == 0 ? 8'h10 : 8'h20};
         StallD      = $urandom_range(0, 4) == 0;
         StallE      = $urandom_range(0, 4) == 0;
         FlushD      = $urandom_range(0, 11) == 0;
         FlushE      = $urandom_range(0, 11) == 0;
         BranchE     = $urandom_range(0, 9) < 4;
         JumpE       = $urandom_range(0, 9) < 2;
         PCSrcE      = $urandom_range(0, 1) == 1;
         ActTargetE  = ($urandom_range(0, 1) == 1) ? etg : {24'd0, 8'h20};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
